dmi_boot_sequencer: RTL and testbench
=====================================

Name: dmi_boot_sequencer

Overview:
Synthesizable hardware master on the debug-module DMI bus. It brings up NrHarts cores from a halted, preloaded memory image. Per hart: activate the DM, select the hart, halt it, write its boot address into dpc through an abstract command, resume it, and confirm resume-ack. It sits between the SoC boot controller and the dm_top DMI port, as an alternative to the JTAG DTM, and is parametrised in hart count and XLEN.

Parameters:
NrHarts, 1, number of harts sequenced (1..1024; hartsel is 10 bits)
XLEN, 32, register width (32 or 64); selects aarsize and whether data1 is written
PollLimit, 1023, maximum status polls per wait state (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle start pulse; accepted only in IDLE/DONE/ERROR
boot_addr_i  in  NrHarts*XLEN  per-hart dpc value, hart h at [h*XLEN +: XLEN]; sampled when the hart's WR_DATA0 is issued
dmi_req_valid_o  out  1  DMI request valid
dmi_req_ready_i  in  1  DMI request ready
dmi_req_o  out  41  {addr[6:0], op[1:0], data[31:0]} (dm::dmi_req_t)
dmi_resp_valid_i  in  1  DMI response valid
dmi_resp_ready_o  out  1  DMI response ready
dmi_resp_i  in  34  {data[31:0], resp[1:0]} (dm::dmi_resp_t)
busy_o  out  1  sequence in progress
done_o  out  1  all harts resumed; held until next start_i
error_o  out  1  sequence aborted; held until next start_i
err_hart_o  out  10  hart index at abort
err_code_o  out  3  1=DMI resp≠0, 2=cmderr≠0, 3=poll timeout

Behaviour:
- Reset: synchronous. All outputs 0, FSM=IDLE, hart counter=0, poll counter=0. Reset mid-transfer drops dmi_req_valid_o in the same edge. Pending responses are not drained.
- DMI handshake: exactly one outstanding request. valid_o is held with a stable payload until valid&&ready. The FSM then waits for resp_valid_i. resp_ready_o=1 only in response-wait sub-state. Response resp≠0 → ERROR, code 1.
- Ops: write op=2, read op=1. Every access is 2 sub-states (REQ, RSP). Minimum latency per access is 2 cycles.
- FSM states and writes (hs = hart index << 16):
  - IDLE: on start_i → ACTIVATE with hart counter=0.
  - ACTIVATE: write 0x10 ← 0x00000001.
  - HALT: write 0x10 ← 0x80000001|hs.
  - POLL_HALT: read 0x11. Repeat until bit9 (allhalted) is set.
  - WR_DATA0: write 0x04 ← addr[31:0].
  - WR_DATA1 (XLEN=64 only): write 0x05 ← addr[63:32].
  - WR_CMD: write 0x17 ← 0x002307B1 for XLEN=32, or 0x003307B1 for XLEN=64. Fields: transfer, write, regno=dpc.
  - POLL_ABS: read 0x16. Repeat while bit12 (busy) is set. Then cmderr[10:8]≠0 → ERROR code 2.
  - RESUME: write 0x10 ← 0x40000001|hs.
  - POLL_RES: read 0x11. Repeat until bit17 (allresumeack) is set.
  - NEXT: if hart == NrHarts-1 → DONE, else increment hart and go to HALT.
  - DONE / ERROR: outputs held. start_i clears done/error and restarts at ACTIVATE.
- busy_o=1 in every state except IDLE/DONE/ERROR. start_i while busy is ignored.
- Poll reads are issued back-to-back with no idle cycles.
- done_o and error_o are mutually exclusive.

Optional Feature:
DMI_BOOT_POLL_TIMEOUT_EN:
- Defined: each poll state counts completed reads and clears the count on state entry. Reaching PollLimit without the exit condition → ERROR, code 3, err_hart_o = current hart.
- Undefined: polling is unbounded, the counter logic is removed, and code 3 never occurs.

Decomposition:
- Shared package dmi_boot_pkg:
  - state enum
  - DMI address constants: DMControl 0x10, DMStatus 0x11, Data0 0x04, Data1 0x05, AbstractCS 0x16, Command 0x17
  - bit positions: allhalted 9, allresumeack 17, busy 12, cmderr 10:8
  - CSR_DPC 0x7B1
  - error-code constants
  - dm::dmi_req_t and dm::dmi_resp_t are reused.
- One sub-module, dmi_access_port: it takes one access (addr, op, data), runs the REQ/RSP handshake, and returns rdata plus a resp-error flag. The top FSM sequences the accesses.

Test Plan:
- NrHarts=1, XLEN=32, boot_addr=0x80000080, model DM always ready with zero-wait responses → exact write sequence 0x10←1, 0x10←0x80000001, 0x04←0x80000080, 0x17←0x002307B1, 0x10←0x40000001; done_o=1, error_o=0.
- NrHarts=3, XLEN=64, hart 2 addr=0x0000_0001_8000_0000 → hart 2 HALT write is 0x80020001, data1 write is 0x00000001, command is 0x003307B1; done after hart 2 only.
- DM holds allhalted=0 for 5 reads and req_ready low for 3 cycles → 6 POLL_HALT reads; payload stable while stalled; sequence completes.
- abstractcs returns busy for 2 reads, then cmderr=3 → error_o=1, err_code_o=2, err_hart_o=0, no RESUME write issued.
- DMI_BOOT_POLL_TIMEOUT_EN, PollLimit=4, allresumeack never set → exactly 4 POLL_RES reads, then error code 3. rst_i asserted mid-request → next cycle valid_o=0 and busy_o=0.

Source files
------------

// File: rtl/dmi_boot_pkg.sv
// Shared types and constants for the DMI boot sequencer: FSM states, DM register
// addresses, status bit positions, error codes and DMI request/response layouts.
package dmi_boot_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ACTIVATE  = 4'd1,
    ST_HALT      = 4'd2,
    ST_POLL_HALT = 4'd3,
    ST_WR_DATA0  = 4'd4,
    ST_WR_DATA1  = 4'd5,
    ST_WR_CMD    = 4'd6,
    ST_POLL_ABS  = 4'd7,
    ST_RESUME    = 4'd8,
    ST_POLL_RES  = 4'd9,
    ST_NEXT      = 4'd10,
    ST_DONE      = 4'd11,
    ST_ERROR     = 4'd12
  } boot_state_e;

  typedef enum logic [1:0] {
    PORT_IDLE = 2'd0,
    PORT_REQ  = 2'd1,
    PORT_RSP  = 2'd2
  } port_state_e;

  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DATA1      = 7'h05;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam int unsigned ALLHALTED_BIT    = 9;
  localparam int unsigned ALLRESUMEACK_BIT = 17;
  localparam int unsigned BUSY_BIT         = 12;
  localparam int unsigned CMDERR_HI        = 10;
  localparam int unsigned CMDERR_LO        = 8;

  localparam logic [11:0] CSR_DPC = 12'h7B1;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_DMI_RESP = 3'd1;
  localparam logic [2:0] ERR_CMDERR   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;

  // Same bit layout as dm::dmi_req_t / dm::dmi_resp_t.
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  function automatic logic [31:0] dmcontrol_word(input logic haltreq, input logic resumereq,
                                                 input logic [9:0] hartsel);
    return {haltreq, resumereq, 4'b0000, hartsel, 15'b0, 1'b1};
  endfunction

  // Access-register command: transfer + write of dpc, aarsize 2 (32b) or 3 (64b).
  function automatic logic [31:0] abs_cmd_dpc(input logic is_rv64);
    logic [2:0] aarsize;
    aarsize = is_rv64 ? 3'd3 : 3'd2;
    return {8'h00, 1'b0, aarsize, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, CSR_DPC};
  endfunction

  function automatic logic is_access_state(input boot_state_e st);
    return (st != ST_IDLE) && (st != ST_NEXT) && (st != ST_DONE) && (st != ST_ERROR);
  endfunction

  function automatic logic is_poll_state(input boot_state_e st);
    return (st == ST_POLL_HALT) || (st == ST_POLL_ABS) || (st == ST_POLL_RES);
  endfunction

endpackage

// File: rtl/dmi_boot_sequencer_access_port.sv
// Single-outstanding DMI master port: latches one access, runs the REQ/RSP
// handshake and reports read data plus a response-error flag.
module dmi_access_port
  import dmi_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        go,
  input  logic [6:0]  addr,
  input  logic [1:0]  op,
  input  logic [31:0] wdata,
  output logic        acc_done,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i
);

  port_state_e port_state_r, port_state_s;
  logic        load_s;
  logic        req_valid_r;
  logic        resp_ready_r;
  dmi_req_t    req_r;
  dmi_resp_t   resp_s;

  assign resp_s           = dmi_resp_i;
  assign acc_done         = (port_state_r == PORT_RSP) && dmi_resp_valid_i;
  assign rdata            = resp_s.data;
  assign resp_err         = (resp_s.resp != 2'b00);
  assign dmi_req_valid_o  = req_valid_r;
  assign dmi_req_o        = req_r;
  assign dmi_resp_ready_o = resp_ready_r;

  // Handshake next-state; a new access may launch in the same cycle a response lands.
  always_comb begin
    port_state_s = port_state_r;
    load_s       = 1'b0;
    case (port_state_r)
      PORT_IDLE: begin
        if (go) begin
          port_state_s = PORT_REQ;
          load_s       = 1'b1;
        end else begin
          port_state_s = PORT_IDLE;
        end
      end
      PORT_REQ: begin
        if (dmi_req_ready_i) begin
          port_state_s = PORT_RSP;
        end else begin
          port_state_s = PORT_REQ;
        end
      end
      PORT_RSP: begin
        if (dmi_resp_valid_i && go) begin
          port_state_s = PORT_REQ;
          load_s       = 1'b1;
        end else if (dmi_resp_valid_i) begin
          port_state_s = PORT_IDLE;
        end else begin
          port_state_s = PORT_RSP;
        end
      end
      default: port_state_s = PORT_IDLE;
    endcase
  end

  // State register and registered DMI outputs; payload only changes on a launch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      port_state_r <= PORT_IDLE;
      req_valid_r  <= 1'b0;
      resp_ready_r <= 1'b0;
      req_r        <= '0;
    end else begin
      port_state_r <= port_state_s;
      req_valid_r  <= (port_state_s == PORT_REQ);
      resp_ready_r <= (port_state_s == PORT_RSP);
      req_r        <= load_s ? dmi_req_t'{addr: addr, op: op, data: wdata} : req_r;
    end
  end

endmodule

// File: rtl/dmi_boot_sequencer.sv
// DMI boot sequencer: activates the DM, then halts, sets dpc and resumes each hart.
// Optional macro DMI_BOOT_POLL_TIMEOUT_EN bounds every poll loop to PollLimit reads.
module dmi_boot_sequencer
  import dmi_boot_pkg::*;
#(
  parameter int unsigned NrHarts   = 1,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PollLimit = 1023
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [NrHarts*XLEN-1:0] boot_addr_i,
  output logic                    dmi_req_valid_o,
  input  logic                    dmi_req_ready_i,
  output logic [40:0]             dmi_req_o,
  input  logic                    dmi_resp_valid_i,
  output logic                    dmi_resp_ready_o,
  input  logic [33:0]             dmi_resp_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [9:0]              err_hart_o,
  output logic [2:0]              err_code_o
);

  boot_state_e state_r, state_s;
  logic [9:0]  hart_r, hart_s;
  logic [2:0]  err_code_r, err_code_s;
  logic [9:0]  err_hart_r, err_hart_s;
  logic        busy_r, done_r, error_r;
  logic        start_ok_s, cmderr_abort_s, timeout_s;
  logic        acc_go_s, acc_done_s, acc_err_s;
  logic [31:0] acc_rdata_s;
  logic [6:0]  acc_addr_s;
  logic [1:0]  acc_op_s;
  logic [31:0] acc_wdata_s;
  logic [XLEN-1:0] hart_addr_s;
  logic [63:0]     addr64_s;

  assign start_ok_s = start_i && !busy_r && !((state_r != ST_IDLE) && (state_r != ST_DONE)
                                              && (state_r != ST_ERROR));
  assign cmderr_abort_s = (state_r == ST_POLL_ABS) && acc_done_s && !acc_rdata_s[BUSY_BIT]
                          && (acc_rdata_s[CMDERR_HI:CMDERR_LO] != 3'd0);
  // Every access-state entry (including poll re-entry) launches exactly one access.
  assign acc_go_s = is_access_state(state_s) && (acc_done_s || !is_access_state(state_r));

`ifdef DMI_BOOT_POLL_TIMEOUT_EN
  localparam int unsigned PollW = $clog2(PollLimit + 1);
  logic [PollW-1:0] poll_cnt_r;

  assign timeout_s = is_poll_state(state_r) && acc_done_s
                     && (poll_cnt_r == PollW'(PollLimit - 1));

  // Completed poll reads in the current poll state; cleared whenever the state changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_cnt_r <= '0;
    end else if (state_s != state_r) begin
      poll_cnt_r <= '0;
    end else if (acc_done_s && is_poll_state(state_r)) begin
      poll_cnt_r <= poll_cnt_r + PollW'(1);
    end else begin
      poll_cnt_r <= poll_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Boot address of the hart the next access belongs to.
  always_comb begin
    hart_addr_s = '0;
    for (int h = 0; h < NrHarts; h++) begin
      hart_addr_s = (hart_s == 10'(h)) ? boot_addr_i[h*XLEN +: XLEN] : hart_addr_s;
    end
  end
  assign addr64_s = 64'(hart_addr_s);

  // Sequencer next-state, hart counter and abort capture.
  always_comb begin
    state_s    = state_r;
    hart_s     = hart_r;
    err_code_s = err_code_r;
    err_hart_s = err_hart_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_s = ST_ACTIVATE;
          hart_s  = 10'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_ACTIVATE: state_s = acc_done_s ? ST_HALT : ST_ACTIVATE;
      ST_HALT:     state_s = acc_done_s ? ST_POLL_HALT : ST_HALT;
      ST_POLL_HALT: begin
        if (acc_done_s && acc_rdata_s[ALLHALTED_BIT]) begin
          state_s = ST_WR_DATA0;
        end else begin
          state_s = ST_POLL_HALT;
        end
      end
      ST_WR_DATA0: begin
        if (acc_done_s) begin
          state_s = (XLEN == 64) ? ST_WR_DATA1 : ST_WR_CMD;
        end else begin
          state_s = ST_WR_DATA0;
        end
      end
      ST_WR_DATA1: state_s = acc_done_s ? ST_WR_CMD : ST_WR_DATA1;
      ST_WR_CMD:   state_s = acc_done_s ? ST_POLL_ABS : ST_WR_CMD;
      ST_POLL_ABS: begin
        if (cmderr_abort_s) begin
          state_s = ST_ERROR;
        end else if (acc_done_s && !acc_rdata_s[BUSY_BIT]) begin
          state_s = ST_RESUME;
        end else begin
          state_s = ST_POLL_ABS;
        end
      end
      ST_RESUME: state_s = acc_done_s ? ST_POLL_RES : ST_RESUME;
      ST_POLL_RES: begin
        if (acc_done_s && acc_rdata_s[ALLRESUMEACK_BIT]) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_POLL_RES;
        end
      end
      ST_NEXT: begin
        if (hart_r == 10'(NrHarts - 1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_HALT;
          hart_s  = hart_r + 10'd1;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    // Abort priority: bus error, then poll timeout, then cmderr.
    if (acc_done_s && acc_err_s) begin
      state_s    = ST_ERROR;
      err_code_s = ERR_DMI_RESP;
      err_hart_s = hart_r;
    end else if (timeout_s && (state_s == state_r)) begin
      state_s    = ST_ERROR;
      err_code_s = ERR_TIMEOUT;
      err_hart_s = hart_r;
    end else if (cmderr_abort_s) begin
      err_code_s = ERR_CMDERR;
      err_hart_s = hart_r;
    end else if (start_ok_s) begin
      err_code_s = ERR_NONE;
      err_hart_s = 10'd0;
    end else begin
      err_code_s = err_code_r;
      err_hart_s = err_hart_r;
    end
  end

  // Payload of the access launched on entry into state_s.
  always_comb begin
    acc_addr_s  = 7'h00;
    acc_op_s    = DMI_OP_NOP;
    acc_wdata_s = 32'h0000_0000;
    case (state_s)
      ST_ACTIVATE: begin
        acc_addr_s  = ADDR_DMCONTROL;
        acc_op_s    = DMI_OP_WRITE;
        acc_wdata_s = dmcontrol_word(1'b0, 1'b0, 10'd0);
      end
      ST_HALT: begin
        acc_addr_s  = ADDR_DMCONTROL;
        acc_op_s    = DMI_OP_WRITE;
        acc_wdata_s = dmcontrol_word(1'b1, 1'b0, hart_s);
      end
      ST_POLL_HALT, ST_POLL_RES: begin
        acc_addr_s = ADDR_DMSTATUS;
        acc_op_s   = DMI_OP_READ;
      end
      ST_WR_DATA0: begin
        acc_addr_s  = ADDR_DATA0;
        acc_op_s    = DMI_OP_WRITE;
        acc_wdata_s = addr64_s[31:0];
      end
      ST_WR_DATA1: begin
        acc_addr_s  = ADDR_DATA1;
        acc_op_s    = DMI_OP_WRITE;
        acc_wdata_s = addr64_s[63:32];
      end
      ST_WR_CMD: begin
        acc_addr_s  = ADDR_COMMAND;
        acc_op_s    = DMI_OP_WRITE;
        acc_wdata_s = abs_cmd_dpc(XLEN == 64);
      end
      ST_POLL_ABS: begin
        acc_addr_s = ADDR_ABSTRACTCS;
        acc_op_s   = DMI_OP_READ;
      end
      ST_RESUME: begin
        acc_addr_s  = ADDR_DMCONTROL;
        acc_op_s    = DMI_OP_WRITE;
        acc_wdata_s = dmcontrol_word(1'b0, 1'b1, hart_s);
      end
      default: begin
        acc_addr_s  = 7'h00;
        acc_op_s    = DMI_OP_NOP;
        acc_wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      hart_r     <= 10'd0;
      err_code_r <= ERR_NONE;
      err_hart_r <= 10'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      hart_r     <= hart_s;
      err_code_r <= err_code_s;
      err_hart_r <= err_hart_s;
      busy_r     <= (state_s != ST_IDLE) && (state_s != ST_DONE) && (state_s != ST_ERROR);
      done_r     <= (state_s == ST_DONE);
      error_r    <= (state_s == ST_ERROR);
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign error_o    = error_r;
  assign err_code_o = err_code_r;
  assign err_hart_o = err_hart_r;

  dmi_access_port u_access_port (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .go               (acc_go_s),
    .addr             (acc_addr_s),
    .op               (acc_op_s),
    .wdata            (acc_wdata_s),
    .acc_done         (acc_done_s),
    .rdata            (acc_rdata_s),
    .resp_err         (acc_err_s),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );

endmodule

// File: tb/tb_dmi_boot_sequencer.sv
// Directed bench: two sequencers (1 hart/XLEN32 and 3 harts/XLEN64) against a small DM model.
module tb_dmi_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, start, req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0]        busy, done, error;
  logic [1:0][40:0]  req;
  logic [1:0][33:0]  resp;
  logic [1:0][9:0]   err_hart;
  logic [1:0][2:0]   err_code;
  logic [31:0]       boot_a;
  logic [191:0]      boot_b;

  // DM model knobs (set by the stimulus) and observations (kept by the model)
  int          stall_knob[2], halt_zeros[2], abs_busy[2];
  logic [2:0]  cmderr_knob[2];
  logic        resack_never[2];
  int          stall_left[2], wcnt[2], rd_status[2], rd_abs[2];
  logic        unstable[2], have_prev[2];
  logic [40:0] prev_req[2];
  logic [38:0] wlog[2][64];

  int checks = 0;
  int errors = 0;

  dmi_boot_sequencer #(.NrHarts(1), .XLEN(32), .PollLimit(1023)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .boot_addr_i(boot_a),
    .dmi_req_valid_o(req_valid[0]), .dmi_req_ready_i(req_ready[0]), .dmi_req_o(req[0]),
    .dmi_resp_valid_i(resp_valid[0]), .dmi_resp_ready_o(resp_ready[0]), .dmi_resp_i(resp[0]),
    .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]),
    .err_hart_o(err_hart[0]), .err_code_o(err_code[0])
  );

  dmi_boot_sequencer #(.NrHarts(3), .XLEN(64), .PollLimit(4)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .boot_addr_i(boot_b),
    .dmi_req_valid_o(req_valid[1]), .dmi_req_ready_i(req_ready[1]), .dmi_req_o(req[1]),
    .dmi_resp_valid_i(resp_valid[1]), .dmi_resp_ready_o(resp_ready[1]), .dmi_resp_i(resp[1]),
    .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]),
    .err_hart_o(err_hart[1]), .err_code_o(err_code[1])
  );

  assign req_ready = {(stall_left[1] == 0), (stall_left[0] == 0)};

  // DM model: one-cycle response after accept, logs writes, scripted status reads
  always @(posedge clk) begin
    logic [31:0] rd_v;
    logic [6:0]  a_v;
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        resp_valid[k] <= 1'b0;
        resp[k]       <= 34'h0;
        wcnt[k]       <= 0;
        rd_status[k]  <= 0;
        rd_abs[k]     <= 0;
        stall_left[k] <= stall_knob[k];
        unstable[k]   <= 1'b0;
        have_prev[k]  <= 1'b0;
      end else begin
        if (req_valid[k]) begin
          if (have_prev[k] && (prev_req[k] != req[k])) unstable[k] <= 1'b1;
          prev_req[k]  <= req[k];
          have_prev[k] <= !req_ready[k];
        end else begin
          have_prev[k] <= 1'b0;
        end
        if (req_valid[k] && !req_ready[k]) stall_left[k] <= stall_left[k] - 1;
        if (req_valid[k] && req_ready[k]) begin
          a_v  = req[k][40:34];
          rd_v = 32'h0;
          if (req[k][33:32] == 2'd2) begin
            wlog[k][wcnt[k] & 63] <= {a_v, req[k][31:0]};
            wcnt[k] <= wcnt[k] + 1;
          end else if (a_v == 7'h11) begin
            rd_v[9]  = (rd_status[k] >= halt_zeros[k]);
            rd_v[17] = !resack_never[k];
            rd_status[k] <= rd_status[k] + 1;
          end else if (a_v == 7'h16) begin
            if (rd_abs[k] < abs_busy[k]) rd_v[12] = 1'b1;
            else rd_v[10:8] = cmderr_knob[k];
            rd_abs[k] <= rd_abs[k] + 1;
          end
          resp[k]       <= {rd_v, 2'b00};
          resp_valid[k] <= 1'b1;
        end else if (resp_valid[k] && resp_ready[k]) begin
          resp_valid[k] <= 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int k);
    @(negedge clk) rst[k] = 1'b1;
    @(negedge clk);
    @(negedge clk) rst[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk) start[k] = 1'b1;
    @(negedge clk) start[k] = 1'b0;
  endtask

  task automatic wait_end(input int k, input string tag, input int max_cycles);
    int n = 0;
    while (!(done[k] || error[k]) && (n < max_cycles)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_finished"}, 64'(done[k] | error[k]), 64'h1);
  endtask

  task automatic set_knobs(input int k, input int stall, input int hz, input int ab,
                           input logic [2:0] ce, input logic rn);
    stall_knob[k]   = stall;
    halt_zeros[k]   = hz;
    abs_busy[k]     = ab;
    cmderr_knob[k]  = ce;
    resack_never[k] = rn;
  endtask

  logic [38:0] exp_a [5];

  initial begin
    rst    = 2'b11;
    start  = 2'b00;
    boot_a = 32'h8000_0080;
    boot_b = {64'h0000_0001_8000_0000, 64'h0000_0002_2000_0004, 64'h0000_0000_1000_0000};
    set_knobs(0, 0, 0, 0, 3'd0, 1'b0);
    set_knobs(1, 0, 0, 0, 3'd0, 1'b0);
    exp_a[0] = {7'h10, 32'h0000_0001};
    exp_a[1] = {7'h10, 32'h8000_0001};
    exp_a[2] = {7'h04, 32'h8000_0080};
    exp_a[3] = {7'h17, 32'h0023_07B1};
    exp_a[4] = {7'h10, 32'h4000_0001};

    // reset state
    do_reset(0);
    check_eq("rst_valid", 64'(req_valid[0]), 64'h0);
    check_eq("rst_resp_ready", 64'(resp_ready[0]), 64'h0);
    check_eq("rst_busy", 64'(busy[0]), 64'h0);
    check_eq("rst_done_error", 64'({done[0], error[0]}), 64'h0);
    check_eq("rst_err_info", 64'({err_hart[0], err_code[0]}), 64'h0);

    // single hart, XLEN=32, zero-wait DM
    pulse_start(0);
    check_eq("a_busy_after_start", 64'(busy[0]), 64'h1);
    wait_end(0, "a_basic", 200);
    check_eq("a_wcnt", 64'(wcnt[0]), 64'd5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("a_write%0d", i), 64'(wlog[0][i]), 64'(exp_a[i]));
    check_eq("a_status_reads", 64'(rd_status[0]), 64'd2);
    check_eq("a_done", 64'({done[0], error[0], busy[0]}), 64'b100);

    // stalled ready and slow allhalted
    set_knobs(0, 3, 5, 0, 3'd0, 1'b0);
    do_reset(0);
    pulse_start(0);
    wait_end(0, "a_stall", 300);
    check_eq("a_stall_consumed", 64'(stall_left[0]), 64'd0);
    check_eq("a_payload_stable", 64'(unstable[0]), 64'h0);
    check_eq("a_halt_polls_plus_res", 64'(rd_status[0]), 64'd7);
    check_eq("a_stall_done", 64'({done[0], error[0]}), 64'b10);

    // abstract command busy twice then cmderr
    set_knobs(0, 0, 0, 2, 3'd3, 1'b0);
    do_reset(0);
    pulse_start(0);
    wait_end(0, "a_cmderr", 200);
    check_eq("a_cmderr_flags", 64'({done[0], error[0], busy[0]}), 64'b010);
    check_eq("a_cmderr_code", 64'(err_code[0]), 64'd2);
    check_eq("a_cmderr_hart", 64'(err_hart[0]), 64'd0);
    check_eq("a_cmderr_abs_reads", 64'(rd_abs[0]), 64'd3);
    check_eq("a_cmderr_no_resume", 64'(wcnt[0]), 64'd4);

    // restart from ERROR clears the error and completes
    cmderr_knob[0] = 3'd0;
    pulse_start(0);
    check_eq("a_restart_clear", 64'({error[0], err_code[0], busy[0]}), 64'b0_000_1);
    wait_end(0, "a_restart", 200);
    check_eq("a_restart_done", 64'({done[0], error[0]}), 64'b10);

    // reset while a request is pending
    set_knobs(0, 10, 0, 0, 3'd0, 1'b0);
    do_reset(0);
    pulse_start(0);
    check_eq("a_pending_valid", 64'(req_valid[0]), 64'h1);
    rst[0] = 1'b1;
    @(negedge clk);
    check_eq("a_midrst_valid", 64'(req_valid[0]), 64'h0);
    check_eq("a_midrst_busy", 64'(busy[0]), 64'h0);
    rst[0] = 1'b0;

    // three harts, XLEN=64
    do_reset(1);
    pulse_start(1);
    wait_end(1, "b_basic", 600);
    check_eq("b_wcnt", 64'(wcnt[1]), 64'd16);
    check_eq("b_h0_halt", 64'(wlog[1][1]), 64'({7'h10, 32'h8000_0001}));
    check_eq("b_h1_data1", 64'(wlog[1][8]), 64'({7'h05, 32'h0000_0002}));
    check_eq("b_h2_halt", 64'(wlog[1][11]), 64'({7'h10, 32'h8002_0001}));
    check_eq("b_h2_data0", 64'(wlog[1][12]), 64'({7'h04, 32'h8000_0000}));
    check_eq("b_h2_data1", 64'(wlog[1][13]), 64'({7'h05, 32'h0000_0001}));
    check_eq("b_h2_cmd", 64'(wlog[1][14]), 64'({7'h17, 32'h0033_07B1}));
    check_eq("b_h2_resume", 64'(wlog[1][15]), 64'({7'h10, 32'h4002_0001}));
    check_eq("b_done", 64'({done[1], error[1], busy[1]}), 64'b100);

`ifdef DMI_BOOT_POLL_TIMEOUT_EN
    // allresumeack never arrives: four POLL_RES reads then timeout
    set_knobs(1, 0, 0, 0, 3'd0, 1'b1);
    do_reset(1);
    pulse_start(1);
    wait_end(1, "b_timeout", 300);
    check_eq("b_timeout_flags", 64'({done[1], error[1]}), 64'b01);
    check_eq("b_timeout_code", 64'(err_code[1]), 64'd3);
    check_eq("b_timeout_hart", 64'(err_hart[1]), 64'd0);
    check_eq("b_timeout_reads", 64'(rd_status[1]), 64'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
